// File: rtl/multi_channel_fifo_arbiter.sv
// Multi-channel FIFO with round-robin arbitration onto one registered
// valid/ready output stream. Each channel has its own FIFO, fill level and
// saturating drop counter.

module mcfa_chan_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int LOG_DEPTH          = 5,
  parameter int ALMOST_FULL_THRESH = 28,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_en_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [LOG_DEPTH:0]    fill_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [CNT_WIDTH-1:0]  drop_count_o,
  output logic                  drop_o
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_LVL = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LOG_DEPTH:0]    fill_q, fill_d;
  logic [CNT_WIDTH-1:0]  drop_q;
  logic                  wr;

  // Full is judged on start-of-cycle fill: no pass-through when draining.
  assign full_o        = (fill_q == FULL_LVL);
  assign almost_full_o = (32'(fill_q) >= ALMOST_FULL_THRESH);
  assign wr            = push_en_i & ~full_o;
  assign drop_o        = push_en_i & full_o;
  assign fill_o        = fill_q;
  assign head_o        = mem_q[rd_ptr_q];
  assign drop_count_o  = drop_q;
  assign fill_d        = fill_q + {{LOG_DEPTH{1'b0}}, wr} - {{LOG_DEPTH{1'b0}}, pop_i};

  // Storage array, deliberately left uninitialised by reset.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers, fill level and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
    end else begin
      if (wr)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q <= fill_d;
      if (drop_o && !(&drop_q)) drop_q <= drop_q + 1'b1;
    end
  end
endmodule

module multi_channel_fifo_arbiter #(
  parameter int N_CHANNELS         = 4,
  parameter int DATA_WIDTH         = 32,
  parameter int LOG_DEPTH          = 5,
  parameter int ALMOST_FULL_THRESH = 28,
  parameter int CNT_WIDTH          = 16,
  localparam int CHAN_W            = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [N_CHANNELS-1:0]                push_en_i,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0]     push_data_i,
  output logic [N_CHANNELS-1:0]                push_full_o,
  output logic [N_CHANNELS-1:0]                push_almost_full_o,
  input  logic                                 pop_ready_i,
  output logic                                 pop_valid_o,
  output logic [DATA_WIDTH-1:0]                pop_data_o,
  output logic [CHAN_W-1:0]                    pop_chan_o,
  output logic [N_CHANNELS*(LOG_DEPTH+1)-1:0]  fill_level_o,
  output logic [N_CHANNELS*CNT_WIDTH-1:0]      drop_count_o,
  output logic                                 error_o
);
  typedef struct packed {
    logic                  vld;
    logic [CHAN_W-1:0]     chan;
    logic [DATA_WIDTH-1:0] data;
  } out_t;

  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] push_data_a, head_a;
  logic [N_CHANNELS-1:0][LOG_DEPTH:0]    fill_a;
  logic [N_CHANNELS-1:0][CNT_WIDTH-1:0]  drop_a;
  logic [N_CHANNELS-1:0]                 gnt, drop;
  logic [CHAN_W-1:0]                     rr_q, gidx, cand;
  logic                                  found, slot_free, error_q;
  out_t                                  out_q;

  assign push_data_a  = push_data_i;
  assign fill_level_o = fill_a;
  assign drop_count_o = drop_a;
  assign slot_free    = ~out_q.vld | pop_ready_i;

  for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
    assign gnt[i] = slot_free & found & (gidx == CHAN_W'(i));
    mcfa_chan_fifo #(
      .DATA_WIDTH(DATA_WIDTH), .LOG_DEPTH(LOG_DEPTH),
      .ALMOST_FULL_THRESH(ALMOST_FULL_THRESH), .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i(clk_i), .reset_i(reset_i),
      .push_en_i(push_en_i[i]), .push_data_i(push_data_a[i]), .pop_i(gnt[i]),
      .full_o(push_full_o[i]), .almost_full_o(push_almost_full_o[i]),
      .fill_o(fill_a[i]), .head_o(head_a[i]),
      .drop_count_o(drop_a[i]), .drop_o(drop[i])
    );
  end

  // Rotating-priority scan: first non-empty channel at or after rr_q.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      cand = CHAN_W'((32'(rr_q) + 32'(k)) % N_CHANNELS);
      if (!found && (fill_a[cand] != '0)) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // Show-ahead output register and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_q <= '0;
      rr_q  <= '0;
    end else if (slot_free) begin
      if (found) begin
        out_q <= '{vld: 1'b1, chan: gidx, data: head_a[gidx]};
        rr_q  <= (32'(gidx) == N_CHANNELS - 1) ? '0 : gidx + 1'b1;
      end else begin
        out_q.vld <= 1'b0;
      end
    end
  end

  // Sticky error flag: any dropped push since reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) error_q <= 1'b0;
    else         error_q <= error_q | (|drop);
  end

  assign pop_valid_o = out_q.vld;
  assign pop_data_o  = out_q.data;
  assign pop_chan_o  = out_q.chan;
  assign error_o     = error_q;
endmodule

// File: tb/tb_multi_channel_fifo_arbiter.sv
// Bench for multi_channel_fifo_arbiter: per-channel scoreboard queues filled
// at push time and drained by a pop monitor, plus a cycle table and
// hand-written corner sequences.

module tb_multi_channel_fifo_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LD = 5;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      push_en = '0;
  logic [N*DW-1:0]   push_data = '0;
  logic [N-1:0]      push_full, push_almost_full;
  logic              pop_ready = 1'b0;
  logic              pop_valid;
  logic [DW-1:0]     pop_data;
  logic [1:0]        pop_chan;
  logic [N*(LD+1)-1:0] fill_level;
  logic [N*CW-1:0]   drop_count;
  logic              error;

  multi_channel_fifo_arbiter #(
    .N_CHANNELS(N), .DATA_WIDTH(DW), .LOG_DEPTH(LD),
    .ALMOST_FULL_THRESH(28), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .push_en_i(push_en), .push_data_i(push_data),
    .push_full_o(push_full), .push_almost_full_o(push_almost_full),
    .pop_ready_i(pop_ready), .pop_valid_o(pop_valid),
    .pop_data_o(pop_data), .pop_chan_o(pop_chan),
    .fill_level_o(fill_level), .drop_count_o(drop_count), .error_o(error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          seq      = 1;
  logic [31:0] mq [N][$];
  int          got_chan [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LD:0] fill(input int i);
    return fill_level[i*(LD+1) +: (LD+1)];
  endfunction

  function automatic logic [CW-1:0] drops(input int i);
    return drop_count[i*CW +: CW];
  endfunction

  // Pop monitor: checks data against the scoreboard and output stability.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic [1:0]  hold_c = '0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(pop_valid), 64'd1);
        chk("hold_data", 64'(pop_data), 64'(hold_d));
        chk("hold_chan", 64'(pop_chan), 64'(hold_c));
      end
      if (pop_valid && pop_ready) begin
        if (mq[pop_chan].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got chan %0d data %0h, expected no word", pop_chan, pop_data);
        end else begin
          chk($sformatf("pop_data_ch%0d", pop_chan), 64'(pop_data), 64'(mq[pop_chan].pop_front()));
        end
        got_chan.push_back(int'(pop_chan));
      end
      hold_v = pop_valid && !pop_ready;
      hold_d = pop_data;
      hold_c = pop_chan;
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic [N-1:0] en, input logic rdy, input logic [N-1:0] dexp,
                     input bit ovr = 1'b0, input logic [31:0] dv = '0);
    push_en   = en;
    pop_ready = rdy;
    for (int i = 0; i < N; i++) begin
      logic [31:0] w;
      w = ovr ? dv : {8'(i), 24'(seq)};
      seq++;
      push_data[i*DW +: DW] = w;
      if (en[i] && !dexp[i]) mq[i].push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    push_en   = '0;
    pop_ready = 1'b0;
    for (int i = 0; i < N; i++) mq[i].delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    got_chan.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(pop_valid), 64'd0);
    chk({tag, "_data"}, 64'(pop_data), 64'd0);
    chk({tag, "_chan"}, 64'(pop_chan), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_fill"}, 64'(fill_level), 64'd0);
    chk({tag, "_drops"}, drop_count, 64'd0);
    chk({tag, "_full"}, 64'(push_full), 64'd0);
    chk({tag, "_afull"}, 64'(push_almost_full), 64'd0);
  endtask

  task automatic drain(input string tag);
    int left;
    for (int c = 0; c < 300; c++) begin
      left = 0;
      for (int i = 0; i < N; i++) left += mq[i].size();
      if (left == 0 && !pop_valid) break;
      cyc('0, 1'b1, '0);
    end
    left = 0;
    for (int i = 0; i < N; i++) left += mq[i].size();
    chk({tag, "_left"}, 64'(left), 64'd0);
    chk({tag, "_valid_after"}, 64'(pop_valid), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0] en;
    logic [31:0]  d;
    logic         rdy;
    logic         ev;
    logic [31:0]  ed;
    logic [1:0]   ec;
    logic [LD:0]  ef2;
  } vec_t;
  vec_t tbl [3];

  task automatic run_table(input string tag);
    for (int r = 0; r < 3; r++) begin
      cyc(tbl[r].en, tbl[r].rdy, '0, 1'b1, tbl[r].d);
      chk($sformatf("%s_r%0d_valid", tag, r), 64'(pop_valid), 64'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk($sformatf("%s_r%0d_data", tag, r), 64'(pop_data), 64'(tbl[r].ed));
        chk($sformatf("%s_r%0d_chan", tag, r), 64'(pop_chan), 64'(tbl[r].ec));
      end
      chk($sformatf("%s_r%0d_fill2", tag, r), 64'(fill(2)), 64'(tbl[r].ef2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    // Push A5 on ch2: valid two cycles later, then the stream goes idle.
    tbl[0] = '{4'b0100, 32'h000000A5, 1'b1, 1'b0, 32'h0,          2'd0, 6'd1};
    tbl[1] = '{4'b0000, 32'h000000A5, 1'b1, 1'b1, 32'h000000A5,   2'd2, 6'd0};
    tbl[2] = '{4'b0000, 32'h000000A5, 1'b1, 1'b0, 32'h0,          2'd0, 6'd0};

    // Test 1: reset state and single-word latency.
    do_reset();
    chk_zero("t0");
    run_table("t1");

    // Test 2: round-robin across all channels.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(4'hF, 1'b1, '0);
    drain("t2");
    chk("t2_npops", 64'(got_chan.size()), 64'd12);
    for (int k = 0; k < 12 && k < got_chan.size(); k++)
      chk($sformatf("t2_chan%0d", k), 64'(got_chan[k]), 64'(k % 4));

    // Test 3: fill ch1 (32 in FIFO + 1 in output register), then 3 drops.
    do_reset();
    for (int k = 0; k < 33; k++) cyc(4'b0010, 1'b0, '0);
    chk("t3_fill32", 64'(fill(1)), 64'd32);
    chk("t3_full_pre", 64'(push_full), 64'b0010);
    for (int k = 0; k < 3; k++) cyc(4'b0010, 1'b0, 4'b0010);
    chk("t3_full", 64'(push_full), 64'b0010);
    chk("t3_afull", 64'(push_almost_full), 64'b0010);
    chk("t3_drops", 64'(drops(1)), 64'd3);
    chk("t3_error", 64'(error), 64'd1);
    chk("t3_fill_after", 64'(fill(1)), 64'd32);
    drain("t3");
    chk("t3_npops", 64'(got_chan.size()), 64'd33);

    // Test 4: random traffic with random backpressure.
    do_reset();
    pushed = 0;
    for (int c = 0; c < 300; c++) begin
      logic [N-1:0] en;
      en = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1 && mq[i].size() < 30) begin
          en[i] = 1'b1;
          pushed++;
        end
      cyc(en, 1'($urandom_range(0, 1)), '0);
    end
    drain("t4");
    chk("t4_npops", 64'(got_chan.size()), 64'(pushed));
    chk("t4_error", 64'(error), 64'd0);
    chk("t4_drops", drop_count, 64'd0);

    // Test 5: push to full ch0 while it is granted, then almost-full edge.
    do_reset();
    for (int k = 0; k < 33; k++) cyc(4'b0001, 1'b0, '0);
    chk("t5_fill32", 64'(fill(0)), 64'd32);
    cyc(4'b0001, 1'b1, 4'b0001);
    chk("t5_fill31", 64'(fill(0)), 64'd31);
    chk("t5_drop", 64'(drops(0)), 64'd1);
    chk("t5_notfull", 64'(push_full[0]), 64'd0);
    chk("t5_error", 64'(error), 64'd1);
    for (int k = 0; k < 3; k++) cyc('0, 1'b1, '0);
    chk("t5_fill28", 64'(fill(0)), 64'd28);
    chk("t5_afull28", 64'(push_almost_full[0]), 64'd1);
    cyc('0, 1'b1, '0);
    chk("t5_fill27", 64'(fill(0)), 64'd27);
    chk("t5_afull27", 64'(push_almost_full[0]), 64'd0);
    drain("t5");

    // Test 6: reset with words queued and output valid.
    for (int k = 0; k < 10; k++) cyc(4'(1 << (k % 4)), 1'b0, '0);
    chk("t6_valid_pre", 64'(pop_valid), 64'd1);
    chk("t6_error_pre", 64'(error), 64'd1);
    do_reset();
    chk_zero("t6");
    run_table("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
